ccd_pixel_capture: RTL
======================

# ccd_pixel_capture

Downstream readout stage of the CCD clock generator. Consumes the transfer pulse `phi_p` and reset-gate clock `phi_r` and issues one ADC conversion per pixel at a fixed delay after each `phi_r` falling edge. Dummy pixels are discarded. Valid pixels are buffered in a small FIFO and presented as a valid/ready stream with start-of-line and end-of-line markers for the frame/UART logic.

## Interface
Parameters:
- `N_PIXELS`, 2048: active pixels per line.
- `DUMMY_PIXELS`, 32: leading pixels converted but discarded.
- `SAMPLE_DELAY`, 8: `clk` cycles from detected `phi_r` fall to `adc_start`. Range 1..255.
- `ADC_WIDTH`, 12: ADC sample width.
- `FIFO_DEPTH`, 16: output buffer entries. Power of two, ≥2.

Ports:
- `clk` in 1: system clock, same clock as the `phi_p` pulse generator.
- `rst` in 1: synchronous, active-high reset.
- `phi_p` in 1: line transfer pulse. Treated as asynchronous.
- `phi_r` in 1: pixel reset clock. Asynchronous, 130 kHz nominal.
- `adc_start` out 1: one-cycle conversion strobe.
- `adc_data` in ADC_WIDTH: conversion result, valid with `adc_valid`.
- `adc_valid` in 1: one-cycle result strobe.
- `pix_data` out ADC_WIDTH: buffered pixel.
- `pix_sol` out 1: `pix_data` is active pixel 0.
- `pix_eol` out 1: `pix_data` is active pixel N_PIXELS-1.
- `pix_valid` out 1: stream valid.
- `pix_ready` in 1: stream ready.
- `line_count` out 16: lines started since reset. Wraps 0xFFFF→0.
- `err_overflow` out 1: sticky. A sample was dropped because the FIFO was full.
- `err_line` out 1: sticky. A `phi_p` arrived mid-line, or a conversion was missed.

## Operation
- `phi_p` and `phi_r` each pass through a 2-flop synchronizer, then a registered edge detector.
- FSM states: IDLE, WAIT_R, DELAY, CONVERT.
  - IDLE: on `phi_p` rise, clear the pixel index, increment `line_count`, and go to WAIT_R.
  - WAIT_R: on `phi_r` fall, load the delay counter with SAMPLE_DELAY and go to DELAY.
  - DELAY: decrement the counter. At 0, pulse `adc_start` and go to CONVERT.
  - CONVERT: on `adc_valid`, store the sample and increment the index. If the index reaches DUMMY_PIXELS+N_PIXELS, go to IDLE; otherwise go to WAIT_R.
- Store rule: index < DUMMY_PIXELS → discard. Otherwise push {eol, sol, data}. sol = (index == DUMMY_PIXELS); eol = (index == DUMMY_PIXELS+N_PIXELS-1).
- FIFO full at push: drop the sample and set `err_overflow`. The index still advances, so later pixel positions stay correct.
- `phi_p` rise in any state other than IDLE:
  - Set `err_line`.
  - Abandon the current line; no eol is emitted and FIFO contents are kept.
  - Restart as in IDLE, including the `line_count` increment.
- `phi_r` fall in DELAY or CONVERT: the conversion is missed.
  - Set `err_line`.
  - Any pending `adc_valid` is ignored.
  - Increment the index without a push.
  - Restart DELAY.
- `phi_r` edges in IDLE are ignored. `adc_valid` outside CONVERT is ignored.
- Simultaneous `phi_p` rise and `adc_valid` in CONVERT: `phi_p` wins and the sample is not stored.
- Stream: a word transfers when `pix_valid && pix_ready`. `pix_data`, `pix_sol` and `pix_eol` hold stable while `pix_valid && !pix_ready`.
- A push and a pop in the same cycle on a full FIFO succeeds (no overflow).

## Timing
- `rst` values:
  - FSM = IDLE, all counters 0.
  - `adc_start`, `pix_valid`, `pix_sol`, `pix_eol`, `err_*` = 0.
  - `line_count` = 0, `pix_data` = 0.
  - FIFO empty; synchronizer flops reset to 0.
- Edge-detect latency: 3 `clk` from the input transition to the FSM acting (2 sync + 1 edge register).
- `adc_start` asserts exactly 3+SAMPLE_DELAY cycles after the `phi_r` fall reaches the synchronizer input.
- `line_count` updates 3 cycles after the `phi_p` rise.
- Push occurs in the cycle after `adc_valid`. `pix_valid` rises the cycle after the push into an empty FIFO (FWFT, registered output).
- Pop latency: 1 cycle from handshake to the next word.
- `rst` mid-line takes effect on the next edge; FIFO contents are discarded.

## Structure
- Package `ccd_pkg`:
  - FSM state enum `cap_state_t`.
  - `LINE_CNT_W` = 16.
  - FIFO word layout {eol, sol, data} as a packed struct parameterized by `ADC_WIDTH`.
- Sub-module `ccd_pix_fifo`: synchronous FWFT FIFO with full/empty flags, depth `FIFO_DEPTH`, width ADC_WIDTH+2. It is instantiated once.
- Synchronizers and edge detectors stay inline in the top.

## Test plan
Bench parameters: N_PIXELS=8, DUMMY_PIXELS=2, SAMPLE_DELAY=4, FIFO_DEPTH=4. ADC model returns 0x100+index, 5 cycles after `adc_start`.
1. Normal line: `phi_p` pulse, then 10 `phi_r` periods with `pix_ready`=1 → 8 words 0x102..0x109; sol on 0x102, eol on 0x109; `line_count`=1; errors 0.
2. Sample timing: `phi_r` fall at cycle t → `adc_start` high at exactly t+7, width 1 cycle.
3. Backpressure: `pix_ready`=0 for the whole line → 4 words buffered (0x102..0x105), `err_overflow`=1. Then raise ready → 0x102..0x105 drain in order, with `pix_data` stable while stalled.
4. Mid-line `phi_p` after 5 conversions → `err_line`=1, `line_count`=2, new line emits sol on its third conversion.
5. Missed conversion: ADC delay set to 20 cycles with `phi_r` period 12 → `err_line`=1, no push for the missed index.
6. `rst` asserted during CONVERT with FIFO holding 3 words → next cycle `pix_valid`=0, `line_count`=0, FSM IDLE; a stray `adc_valid` afterwards is ignored.

Source files
------------

// File: rtl/ccd_pkg.sv
// Shared types and widths for the CCD pixel capture slice.
package ccd_pkg;

  localparam int LINE_CNT_W = 16;
  localparam int DELAY_W    = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_R  = 2'd1,
    DELAY   = 2'd2,
    CONVERT = 2'd3
  } cap_state_t;

endpackage

// File: rtl/ccd_pix_fifo.sv
// Synchronous first-word-fall-through FIFO for captured pixel words.
module ccd_pix_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  always_comb begin
    empty   = (count == '0);
    full    = (count == FULL_CNT);
    // Head is forced to zero while empty so the stream reads 0 after reset.
    rd_data = empty ? '0 : mem[rd_ptr];
  end

  // A simultaneous pop frees the slot, so a push into a full FIFO succeeds.
  always_comb begin
    do_rd = rd_en && !empty;
    do_wr = wr_en && (!full || do_rd);
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ccd_pixel_capture.sv
// CCD readout: phi_r-timed ADC conversion, dummy discard, buffered pixel stream.
module ccd_pixel_capture
  import ccd_pkg::*;
#(
  parameter int N_PIXELS     = 2048,
  parameter int DUMMY_PIXELS = 32,
  parameter int SAMPLE_DELAY = 8,
  parameter int ADC_WIDTH    = 12,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  phi_p,
  input  logic                  phi_r,
  output logic                  adc_start,
  input  logic [ADC_WIDTH-1:0]  adc_data,
  input  logic                  adc_valid,
  output logic [ADC_WIDTH-1:0]  pix_data,
  output logic                  pix_sol,
  output logic                  pix_eol,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [LINE_CNT_W-1:0] line_count,
  output logic                  err_overflow,
  output logic                  err_line
);

  localparam int TOTAL = DUMMY_PIXELS + N_PIXELS;
  localparam int IDX_W = $clog2(TOTAL + 1);

  localparam logic [IDX_W-1:0]   IDX_FIRST  = IDX_W'(DUMMY_PIXELS);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(TOTAL - 1);
  localparam logic [IDX_W-1:0]   IDX_END    = IDX_W'(TOTAL);
  localparam logic [DELAY_W-1:0] DELAY_LOAD = DELAY_W'(SAMPLE_DELAY);

  typedef struct packed {
    logic                 eol;
    logic                 sol;
    logic [ADC_WIDTH-1:0] data;
  } pix_word_t;

  logic phi_p_s1, phi_p_s2, phi_p_d;
  logic phi_r_s1, phi_r_s2, phi_r_d;
  logic p_rise, r_fall;

  cap_state_t         state;
  logic [DELAY_W-1:0] dly_cnt;
  logic [IDX_W-1:0]   pix_idx;
  logic [IDX_W-1:0]   idx_next;
  logic               push_en;
  pix_word_t          push_word;
  pix_word_t          head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      phi_p_s1 <= 1'b0;
      phi_p_s2 <= 1'b0;
      phi_p_d  <= 1'b0;
      phi_r_s1 <= 1'b0;
      phi_r_s2 <= 1'b0;
      phi_r_d  <= 1'b0;
    end else begin
      phi_p_s1 <= phi_p;
      phi_p_s2 <= phi_p_s1;
      phi_p_d  <= phi_p_s2;
      phi_r_s1 <= phi_r;
      phi_r_s2 <= phi_r_s1;
      phi_r_d  <= phi_r_s2;
    end
  end

  always_comb begin
    p_rise   = phi_p_s2 && !phi_p_d;
    r_fall   = !phi_r_s2 && phi_r_d;
    idx_next = pix_idx + 1'b1;
  end

  // phi_p restarts the line from any state; a phi_r fall while a conversion
  // is outstanding skips that pixel and re-arms the sample delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dly_cnt    <= '0;
      pix_idx    <= '0;
      line_count <= '0;
      adc_start  <= 1'b0;
      push_en    <= 1'b0;
      push_word  <= '0;
      err_line   <= 1'b0;
    end else begin
      adc_start <= 1'b0;
      push_en   <= 1'b0;
      if (p_rise) begin
        if (state != IDLE) begin
          err_line <= 1'b1;
        end
        pix_idx    <= '0;
        line_count <= line_count + 1'b1;
        state      <= WAIT_R;
      end else begin
        case (state)
          IDLE: ;
          WAIT_R: begin
            if (r_fall) begin
              dly_cnt <= DELAY_LOAD;
              state   <= DELAY;
            end
          end
          DELAY: begin
            if (r_fall) begin
              err_line <= 1'b1;
              pix_idx  <= idx_next;
              if (idx_next == IDX_END) begin
                state <= IDLE;
              end else begin
                dly_cnt <= DELAY_LOAD;
                state   <= DELAY;
              end
            end else if (dly_cnt < DELAY_W'(2)) begin
              dly_cnt   <= '0;
              adc_start <= 1'b1;
              state     <= CONVERT;
            end else begin
              dly_cnt <= dly_cnt - 1'b1;
            end
          end
          CONVERT: begin
            if (r_fall) begin
              err_line <= 1'b1;
              pix_idx  <= idx_next;
              if (idx_next == IDX_END) begin
                state <= IDLE;
              end else begin
                dly_cnt <= DELAY_LOAD;
                state   <= DELAY;
              end
            end else if (adc_valid) begin
              if (pix_idx >= IDX_FIRST) begin
                push_en        <= 1'b1;
                push_word.eol  <= (pix_idx == IDX_LAST);
                push_word.sol  <= (pix_idx == IDX_FIRST);
                push_word.data <= adc_data;
              end
              pix_idx <= idx_next;
              state   <= (idx_next == IDX_END) ? IDLE : WAIT_R;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow <= 1'b0;
    end else if (push_en && fifo_full && !pop) begin
      err_overflow <= 1'b1;
    end
  end

  always_comb begin
    pix_valid = !fifo_empty;
    pop       = pix_valid && pix_ready;
    pix_data  = head.data;
    pix_sol   = head.sol;
    pix_eol   = head.eol;
  end

  ccd_pix_fifo #(
    .WIDTH ($bits(pix_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_en),
    .wr_data (push_word),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule
